// File: rtl/arm_dp_sequencer.sv
// Four-state sequencer for ARM data-processing instructions: condition check,
// operand fetch, ALU drive, write-back and ownership of the NZCV flags.
module arm_dp_sequencer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    output logic        instr_ready,
    output logic [3:0]  rf_raddr_a,
    output logic [3:0]  rf_raddr_b,
    input  logic [31:0] rf_rdata_a,
    input  logic [31:0] rf_rdata_b,
    output logic        rf_we,
    output logic [3:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [4:0]  alu_op,
    output logic        alu_s,
    output logic        alu_out_en,
    output logic [3:0]  alu_flags,
    input  logic [31:0] alu_result,
    input  logic [3:0]  alu_flags_out,
    output logic [3:0]  nzcv,
    output logic        done,
    output logic        skipped,
    output logic        illegal
);

    typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;

    localparam logic [4:0] OP_IDLE = 5'b10000;

    state_t      state;
    logic [3:0]  cond_q;
    logic        imm_q;
    logic [3:0]  opc_q;
    logic        s_q;
    logic [3:0]  rd_q;
    logic [11:0] op2_q;
    logic [3:0]  flags_q;
    logic        upd_flags;

    logic [63:0] imm_dbl;
    logic [31:0] op_b;
    logic        cond_ok;
    logic        bad_shift;
    logic        is_cmp;
    logic [4:0]  exec_op;
    logic        unused_bits;

    function automatic logic cond_pass(input logic [3:0] c,
                                       input logic [3:0] f);
        logic n, z, cy, v, p;
        n  = f[3];
        z  = f[2];
        cy = f[1];
        v  = f[0];
        p  = 1'b0;
        unique case (c)
            4'h0: p = z;
            4'h1: p = !z;
            4'h2: p = cy;
            4'h3: p = !cy;
            4'h4: p = n;
            4'h5: p = !n;
            4'h6: p = v;
            4'h7: p = !v;
            4'h8: p = cy && !z;
            4'h9: p = !cy || z;
            4'hA: p = (n == v);
            4'hB: p = (n != v);
            4'hC: p = !z && (n == v);
            4'hD: p = z || (n != v);
            4'hE: p = 1'b1;
            4'hF: p = 1'b0;
        endcase
        return p;
    endfunction

    // Rotating a doubled copy right leaves the rotated value in the low word.
    assign imm_dbl     = {24'd0, op2_q[7:0], 24'd0, op2_q[7:0]}
                         >> {op2_q[11:8], 1'b0};
    assign op_b        = imm_q ? imm_dbl[31:0] : rf_rdata_b;
    assign cond_ok     = cond_pass(cond_q, nzcv);
    assign bad_shift   = !imm_q && (op2_q[11:4] != 8'd0);
    assign is_cmp      = (opc_q[3:2] == 2'b10);
    assign exec_op     = (opc_q == 4'hD) ? OP_IDLE : {1'b0, opc_q};
    assign alu_flags   = nzcv;
    assign unused_bits = &{1'b0, instr[27:26]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            cond_q      <= '0;
            imm_q       <= 1'b0;
            opc_q       <= '0;
            s_q         <= 1'b0;
            rd_q        <= '0;
            op2_q       <= '0;
            flags_q     <= '0;
            upd_flags   <= 1'b0;
            instr_ready <= 1'b1;
            rf_raddr_a  <= '0;
            rf_raddr_b  <= '0;
            rf_we       <= 1'b0;
            rf_waddr    <= '0;
            rf_wdata    <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_op      <= OP_IDLE;
            alu_s       <= 1'b0;
            alu_out_en  <= 1'b0;
            nzcv        <= '0;
            done        <= 1'b0;
            skipped     <= 1'b0;
            illegal     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (instr_valid) begin
                        cond_q      <= instr[31:28];
                        imm_q       <= instr[25];
                        opc_q       <= instr[24:21];
                        s_q         <= instr[20];
                        rd_q        <= instr[15:12];
                        op2_q       <= instr[11:0];
                        rf_raddr_a  <= instr[19:16];
                        rf_raddr_b  <= instr[3:0];
                        instr_ready <= 1'b0;
                        state       <= DECODE;
                    end
                end
                DECODE: begin
                    if (bad_shift || !cond_ok) begin
                        // Suppressed: retire straight away, nothing written.
                        done      <= 1'b1;
                        illegal   <= bad_shift;
                        skipped   <= !bad_shift;
                        rf_we     <= 1'b0;
                        upd_flags <= 1'b0;
                        state     <= WB;
                    end else begin
                        alu_a      <= rf_rdata_a;
                        alu_b      <= op_b;
                        alu_op     <= exec_op;
                        alu_s      <= s_q;
                        alu_out_en <= 1'b1;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    alu_out_en <= 1'b0;
                    alu_s      <= 1'b0;
                    alu_op     <= OP_IDLE;
                    rf_wdata   <= alu_result;
                    rf_waddr   <= rd_q;
                    rf_we      <= !is_cmp;
                    flags_q    <= alu_flags_out;
                    upd_flags  <= s_q || is_cmp;
                    done       <= 1'b1;
                    state      <= WB;
                end
                WB: begin
                    if (upd_flags) begin
                        nzcv <= flags_q;
                    end
                    rf_we       <= 1'b0;
                    done        <= 1'b0;
                    skipped     <= 1'b0;
                    illegal     <= 1'b0;
                    upd_flags   <= 1'b0;
                    instr_ready <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arm_dp_sequencer.sv
// Bench for arm_dp_sequencer: directed table, reset abort sequence and
// random instructions against an architectural model with its own ALU stub.
module tb_arm_dp_sequencer;

    logic        clk;
    logic        reset_n;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    logic [3:0]  rf_raddr_a;
    logic [3:0]  rf_raddr_b;
    logic [31:0] rf_rdata_a;
    logic [31:0] rf_rdata_b;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [4:0]  alu_op;
    logic        alu_s;
    logic        alu_out_en;
    logic [3:0]  alu_flags;
    logic [31:0] alu_result;
    logic [3:0]  alu_flags_out;
    logic [3:0]  nzcv;
    logic        done;
    logic        skipped;
    logic        illegal;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] rf [16];
    logic        pre_we;
    logic [3:0]  pre_addr;
    logic [31:0] pre_data;
    logic [31:0] mrf [16];
    logic [3:0]  mnzcv;
    logic [35:0] alu_t;

    arm_dp_sequencer dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .instr_valid  (instr_valid),
        .instr        (instr),
        .instr_ready  (instr_ready),
        .rf_raddr_a   (rf_raddr_a),
        .rf_raddr_b   (rf_raddr_b),
        .rf_rdata_a   (rf_rdata_a),
        .rf_rdata_b   (rf_rdata_b),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_op       (alu_op),
        .alu_s        (alu_s),
        .alu_out_en   (alu_out_en),
        .alu_flags    (alu_flags),
        .alu_result   (alu_result),
        .alu_flags_out(alu_flags_out),
        .nzcv         (nzcv),
        .done         (done),
        .skipped      (skipped),
        .illegal      (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ARM data-processing semantics: returns {result, N, Z, C, V}.
    function automatic logic [35:0] arm_op(input logic [3:0] op,
                                           input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic [3:0] f);
        logic [32:0] s;
        logic [31:0] x, y, r;
        logic ci, arith, c, v;
        arith = 1'b1;
        x = a;
        y = b;
        ci = 1'b0;
        r = '0;
        case (op)
            4'h0, 4'h8: begin arith = 1'b0; r = a & b;  end
            4'h1, 4'h9: begin arith = 1'b0; r = a ^ b;  end
            4'hC:       begin arith = 1'b0; r = a | b;  end
            4'hD:       begin arith = 1'b0; r = b;      end
            4'hE:       begin arith = 1'b0; r = a & ~b; end
            4'hF:       begin arith = 1'b0; r = ~b;     end
            4'h2, 4'hA: begin y = ~b; ci = 1'b1; end
            4'h3:       begin x = b; y = ~a; ci = 1'b1; end
            4'h5:       ci = f[1];
            4'h6:       begin y = ~b; ci = f[1]; end
            4'h7:       begin x = b; y = ~a; ci = f[1]; end
            default:    ci = 1'b0;
        endcase
        if (arith) begin
            s = {1'b0, x} + {1'b0, y} + {32'd0, ci};
            r = s[31:0];
            c = s[32];
            v = (x[31] == y[31]) && (r[31] != x[31]);
        end else begin
            c = f[1];
            v = f[0];
        end
        return {r, r[31], (r == 32'd0), c, v};
    endfunction

    function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
        logic base;
        case (c[3:1])
            3'd0:    base = f[2];
            3'd1:    base = f[1];
            3'd2:    base = f[3];
            3'd3:    base = f[0];
            3'd4:    base = f[1] && !f[2];
            3'd5:    base = (f[3] == f[0]);
            3'd6:    base = !f[2] && (f[3] == f[0]);
            default: base = 1'b1;
        endcase
        if (c == 4'hF) return 1'b0;
        if (c == 4'hE) return 1'b1;
        return base ^ c[0];
    endfunction

    assign rf_rdata_a = rf[rf_raddr_a];
    assign rf_rdata_b = rf[rf_raddr_b];

    always @(posedge clk) begin
        if (pre_we) rf[pre_addr] <= pre_data;
        else if (rf_we) rf[rf_waddr] <= rf_wdata;
    end

    // External ALU: 01101 is not a valid code here, so a wrong MOV mapping shows.
    always_comb begin
        alu_t = '0;
        if (alu_out_en) begin
            if (alu_op == 5'b10000)
                alu_t = arm_op(4'hD, alu_a, alu_b, alu_flags);
            else if (alu_op[4] || alu_op[3:0] == 4'hD)
                alu_t = {32'hBAD0BAD0, 4'hF};
            else
                alu_t = arm_op(alu_op[3:0], alu_a, alu_b, alu_flags);
        end
        alu_result    = alu_t[35:4];
        alu_flags_out = alu_t[3:0];
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        pre_we = 1'b1;
        pre_addr = a;
        pre_data = d;
        mrf[a] = d;
        @(posedge clk);
        #1 pre_we = 1'b0;
    endtask

    task automatic issue(input logic [31:0] ins, output int lat,
                         output logic skp, output logic ill,
                         output logic we, output logic en,
                         output logic [4:0] op, output logic [31:0] bval,
                         output logic ok, output logic rdy);
        lat = 0; skp = 0; ill = 0; we = 0; en = 0;
        op = '0; bval = '0; ok = 0;
        instr = ins;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        instr = $urandom;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (alu_out_en) begin en = 1; op = alu_op; bval = alu_b; end
            if (rf_we) we = 1;
            if (done) begin
                lat = k; skp = skipped; ill = illegal; ok = 1;
                break;
            end
        end
        @(negedge clk);
        rdy = instr_ready;
    endtask

    task automatic run_checked(input logic [31:0] ins);
        logic [3:0] op, rd;
        logic ill, exe, wr;
        logic [31:0] a, b;
        logic [35:0] t;
        int lat;
        logic skp_a, ill_a, we_a, en_a, ok, rdy;
        logic [4:0] op_a;
        logic [31:0] b_a;
        op = ins[24:21];
        rd = ins[15:12];
        ill = !ins[25] && (ins[11:4] != 8'd0);
        exe = !ill && cond_ok(ins[31:28], mnzcv);
        wr = exe && (op[3:2] != 2'b10);
        if (ins[25]) begin
            b = {24'd0, ins[7:0]};
            repeat (2 * ins[11:8]) b = {b[0], b[31:1]};
        end else begin
            b = mrf[ins[3:0]];
        end
        a = mrf[ins[19:16]];
        t = arm_op(op, a, b, mnzcv);
        if (wr) mrf[rd] = t[35:4];
        if (exe && (ins[20] || op[3:2] == 2'b10)) mnzcv = t[3:0];
        issue(ins, lat, skp_a, ill_a, we_a, en_a, op_a, b_a, ok, rdy);
        check("rnd_timeout", ok, 1);
        check("rnd_latency", lat, exe ? 3 : 2);
        check("rnd_skipped", skp_a, !ill && !exe);
        check("rnd_illegal", ill_a, ill);
        check("rnd_we", we_a, wr);
        check("rnd_alu_en", en_a, exe);
        if (exe) check("rnd_alu_b", b_a, b);
        check("rnd_rd", rf[rd], mrf[rd]);
        check("rnd_nzcv", nzcv, mnzcv);
        check("rnd_ready", rdy, 1);
    endtask

    typedef struct {
        logic [31:0] ins;
        logic [3:0]  rd;
        logic [31:0] val;
        logic        we;
        logic [3:0]  f;
        logic        skp;
        logic        ill;
        int          lat;
        logic        en;
        logic [4:0]  op;
        logic [31:0] b;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        logic skp, ill, we, en, ok, rdy;
        logic [4:0] op;
        logic [31:0] bv;

        vecs[0] = '{32'hE2912001, 4'd2, 32'h80000000, 1, 4'b1001, 0, 0, 3, 1, 5'b00100, 32'h1};
        vecs[1] = '{32'hE1530004, 4'd0, 32'h0,        0, 4'b0110, 0, 0, 3, 1, 5'b01010, 32'h5};
        vecs[2] = '{32'h03A000FF, 4'd0, 32'hFF,       1, 4'b0110, 0, 0, 3, 1, 5'b10000, 32'hFF};
        vecs[3] = '{32'h13A050FF, 4'd5, 32'h0,        0, 4'b0110, 1, 0, 2, 0, 5'b0, 32'h0};
        vecs[4] = '{32'hE3A064FF, 4'd6, 32'hFF000000, 1, 4'b0110, 0, 0, 3, 1, 5'b10000, 32'hFF000000};
        vecs[5] = '{32'hE0917084, 4'd7, 32'h0,        0, 4'b0110, 0, 1, 2, 0, 5'b0, 32'h0};
        vecs[6] = '{32'hF3A080FF, 4'd8, 32'h0,        0, 4'b0110, 1, 0, 2, 0, 5'b0, 32'h0};

        reset_n = 1'b0;
        instr_valid = 1'b0;
        instr = '0;
        pre_we = 1'b0;
        pre_addr = '0;
        pre_data = '0;
        repeat (2) @(negedge clk);
        check("rst_nzcv", nzcv, 0);
        check("rst_done", done, 0);
        check("rst_rf_we", rf_we, 0);
        check("rst_alu_en", alu_out_en, 0);
        check("rst_alu_op", alu_op, 5'b10000);
        check("rst_alu_a", alu_a, 0);
        check("rst_raddr_a", rf_raddr_a, 0);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_ready", instr_ready, 1);

        for (int r = 0; r < 16; r++) preload(4'(r), 32'd0);
        preload(4'd1, 32'h7FFFFFFF);
        preload(4'd3, 32'd5);
        preload(4'd4, 32'd5);

        foreach (vecs[i]) begin
            issue(vecs[i].ins, lat, skp, ill, we, en, op, bv, ok, rdy);
            check($sformatf("vec%0d_timeout", i), ok, 1);
            check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
            check($sformatf("vec%0d_skipped", i), skp, vecs[i].skp);
            check($sformatf("vec%0d_illegal", i), ill, vecs[i].ill);
            check($sformatf("vec%0d_we", i), we, vecs[i].we);
            check($sformatf("vec%0d_alu_en", i), en, vecs[i].en);
            if (vecs[i].en) begin
                check($sformatf("vec%0d_alu_op", i), op, vecs[i].op);
                check($sformatf("vec%0d_alu_b", i), bv, vecs[i].b);
            end
            check($sformatf("vec%0d_rd", i), rf[vecs[i].rd], vecs[i].val);
            check($sformatf("vec%0d_nzcv", i), nzcv, vecs[i].f);
            check($sformatf("vec%0d_ready", i), rdy, 1);
        end

        // Reset during EXEC of ADDS R9, R1, #1 must abort cleanly.
        preload(4'd9, 32'h12345678);
        instr = 32'hE2919001;
        instr_valid = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("abort_in_exec", alu_out_en, 1);
        reset_n = 1'b0;
        #1;
        check("abort_rf_we", rf_we, 0);
        check("abort_done", done, 0);
        check("abort_nzcv", nzcv, 0);
        check("abort_alu_en", alu_out_en, 0);
        check("abort_alu_a", alu_a, 0);
        check("abort_alu_op", alu_op, 5'b10000);
        repeat (2) @(negedge clk);
        check("abort_r9", rf[9], 32'h12345678);
        reset_n = 1'b1;
        @(negedge clk);
        check("abort_ready", instr_ready, 1);

        mnzcv = 4'd0;
        for (int r = 0; r < 16; r++) preload(4'(r), $urandom);
        preload(4'd1, 32'h7FFFFFFF);
        run_checked(32'hE2912001);

        for (int n = 0; n < 60; n++) begin
            logic [3:0] c;
            logic [11:0] op2;
            logic im;
            c = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hE;
            im = 1'($urandom);
            if (im || $urandom_range(0, 7) == 0) op2 = 12'($urandom);
            else op2 = {8'd0, 4'($urandom)};
            run_checked({c, 2'b00, im, 4'($urandom), 1'($urandom),
                         4'($urandom), 4'($urandom), op2});
        end

        for (int r = 0; r < 16; r++)
            check($sformatf("final_r%0d", r), rf[r], mrf[r]);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/arm_dp_sequencer.md
# arm_dp_sequencer

Multi-cycle control block that drives the data-processing ALU. It accepts one 32-bit ARM data-processing instruction per handshake and checks its condition field against the held NZCV status. It then reads operands from the register file, drives the ALU opcode/operand/enable lines, captures the result and flags, writes back to the register file and updates NZCV. It sits between the instruction fetch/decode front end and the combinational ALU, and owns the architectural status flags.

## Interface
- No parameters (data width 32, register address width 4, fixed).
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- instr_valid  in  1  instruction offered
- instr  in  32  ARM data-processing encoding (cond[31:28], I[25], opcode[24:21], S[20], Rn[19:16], Rd[15:12], operand2[11:0])
- instr_ready  out  1  high only in IDLE
- rf_raddr_a / rf_raddr_b  out  4  Rn / Rm read addresses (combinational-read register file)
- rf_rdata_a / rf_rdata_b  in  32  read data, valid in the same cycle as the address
- rf_we  out  1; rf_waddr  out  4; rf_wdata  out  32  single-cycle write port
- alu_a, alu_b  out  32  ALU operands
- alu_op  out  5  ALU opcode
- alu_s  out  1  ALU flag-update enable
- alu_out_en  out  1  ALU result drive enable
- alu_flags  out  4  current NZCV presented to the ALU
- alu_result  in  32; alu_flags_out  in  4  combinational ALU returns
- nzcv  out  4  status register {N,Z,C,V} = bits [3:0]
- done  out  1  one-cycle retire pulse
- skipped  out  1  qualifies done: condition failed
- illegal  out  1  qualifies done: unsupported encoding

## Operation
- States: IDLE, DECODE, EXEC, WB.
- IDLE: instr_ready=1. On instr_valid&&instr_ready, latch instr, go to DECODE.
- DECODE:
  - Drive rf_raddr_a=Rn and rf_raddr_b=instr[3:0]; latch rf_rdata_a into opA.
  - opB = I ? imm8 rotated right by 2*rot[11:8] : rf_rdata_b.
  - Condition evaluated on nzcv, standard ARM table: EQ..LE, AL=1110 passes, 1111 never passes.
  - If the condition fails, or I=0 with instr[11:4]≠0 (shifted register, unsupported), go to WB with all writes suppressed. Otherwise go to EXEC.
- EXEC:
  - alu_a=opA, alu_b=opB, alu_out_en=1, alu_s=S.
  - alu_op={1'b0,opcode}, except MOV(1101) → 5'b10000.
  - At cycle end, latch alu_result and alu_flags_out.
- WB:
  - done=1. rf_we=1 with rf_waddr=Rd, rf_wdata=result, unless the opcode is TST/TEQ/CMP/CMN (10xx) or the instruction was suppressed.
  - nzcv←latched flags if S=1 and not suppressed. TST/TEQ/CMP/CMN always update nzcv when executed, regardless of S.
  - Return to IDLE.
- alu_flags always equals nzcv.
- Outside EXEC: alu_out_en=0, alu_s=0, alu_op=5'b10000; alu_a and alu_b hold their last values.
- skipped and illegal are valid only while done=1 and are otherwise 0. If both conditions apply, illegal=1 and skipped=0.

## Timing
- Reset (asynchronous, immediate): state=IDLE, nzcv=0, instr_ready=1 after reset deasserts, done/skipped/illegal/rf_we/alu_out_en/alu_s=0, alu_a/alu_b/rf_wdata=0, rf_waddr=0, rf_raddr_a/b=0.
- Reset asserted mid-instruction aborts it: no write, no flag update, no done.
- Executed instruction: accept at edge 0; DECODE in cycle 1, EXEC in cycle 2, WB/done in cycle 3; instr_ready high again in cycle 4. Throughput is one instruction per 4 cycles.
- Suppressed instruction: DECODE in cycle 1, done in cycle 2.
- The register write and the nzcv update both take effect at the WB-ending edge. A following instruction's DECODE therefore sees the new register and flag values; no forwarding is needed.
- instr is sampled only at acceptance; changes on instr while busy are ignored.

## Test plan
- ADD with I=1, imm8=0x01, rot=0, Rn=R1=0x7FFFFFFF, S=1, Rd=R2 → alu_op=00100; done in cycle 3; R2=0x80000000; nzcv=1001.
- CMP with Rn=R3=5, Rm=R4=5 (register form) → rf_we never asserted; nzcv Z=1, C=1; a following EQ MOV with imm=0xFF executes (R0=0xFF) and a NE MOV is skipped (skipped=1, done in cycle 2).
- Immediate rotate: imm8=0xFF, rot=4 → alu_b=0xFF000000. MOV selects alu_op=10000, Rd receives 0xFF000000, and nzcv is unchanged (S=0).
- Register operand with instr[11:4]=0x08 → illegal=1 in the done cycle; no write; nzcv unchanged.
- cond=1111 with AL-style encoding → skipped=1, no ALU enable pulse.
- Assert reset_n=0 during EXEC of an ADD with S=1 → no rf_we, nzcv=0, outputs at reset values; after release, instr_ready=1 and a new instruction completes normally.
